dma_axi32_ar_arb: RTL

- Read-address arbiter and outstanding-transaction scheduler for the single 32-bit AXI master port 0 of the DMA.
- Shares the AR channel between CH_NUM DMA channel read engines using round-robin arbitration.
- Tags each command with ARID equal to the channel index.
- Tracks outstanding read bursts and throttles issue when MAX_OUTS bursts are in flight.
- Sits between the channel read-command logic and the AR/R ports of dma_axi32 toward the AXI slave.

---
 rtl/dma_axi32_ar_arb.sv | 121 ++++++++++++
 1 files changed

// File: rtl/dma_axi32_ar_arb.sv
// Round-robin AR channel arbiter for DMA master port 0: tags each burst with its
// channel index and throttles issue once MAX_OUTS read bursts are outstanding.
module dma_axi32_ar_arb #(
    parameter int CH_NUM   = 8,
    parameter int ID_BITS  = 3,
    parameter int LEN_BITS = 4,
    parameter int MAX_OUTS = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CH_NUM-1:0]          ch_req,
    input  logic [CH_NUM*32-1:0]       ch_addr,
    input  logic [CH_NUM*LEN_BITS-1:0] ch_len,
    input  logic [CH_NUM*2-1:0]        ch_size,
    output logic [CH_NUM-1:0]          ch_gnt,
    output logic [ID_BITS-1:0]         ARID,
    output logic [31:0]                ARADDR,
    output logic [LEN_BITS-1:0]        ARLEN,
    output logic [1:0]                 ARSIZE,
    output logic                       ARVALID,
    input  logic                       ARREADY,
    input  logic                       RVALID,
    input  logic                       RREADY,
    input  logic                       RLAST,
    output logic [3:0]                 outs_cnt,
    output logic                       idle
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;

    logic [0:0]          r_state;
    logic [ID_BITS-1:0]  r_rr_ptr;
    logic [ID_BITS-1:0]  r_arid;
    logic [31:0]         r_araddr;
    logic [LEN_BITS-1:0] r_arlen;
    logic [1:0]          r_arsize;
    logic                r_arvalid;
    logic [3:0]          r_outs;

    logic [ID_BITS:0]    w_cand;
    logic                w_found;
    logic [ID_BITS-1:0]  w_win;
    logic                w_hs;
    logic                w_rdone;
    logic                w_can_issue;

    // Scan from the highest offset down so the nearest requester after rr_ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int k = CH_NUM; k >= 1; k--) begin
            w_cand = {1'b0, r_rr_ptr} + (ID_BITS+1)'(k);
            if (w_cand >= (ID_BITS+1)'(CH_NUM))
                w_cand = w_cand - (ID_BITS+1)'(CH_NUM);
            if (|(ch_req & (CH_NUM'(1) << w_cand))) begin
                w_found = 1'b1;
                w_win   = w_cand[ID_BITS-1:0];
            end
        end
    end

    assign w_hs        = r_arvalid & ARREADY;
    assign w_rdone     = RVALID & RREADY & RLAST;
    assign w_can_issue = w_found && (r_outs < 4'(MAX_OUTS));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_arvalid <= 1'b0;
            r_rr_ptr  <= ID_BITS'(CH_NUM - 1);
            r_arid    <= '0;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_arsize  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_can_issue) begin
                        r_state   <= ISSUE;
                        r_arvalid <= 1'b1;
                        r_arid    <= w_win;
                        r_araddr  <= 32'(ch_addr >> (32 * w_win));
                        r_arlen   <= LEN_BITS'(ch_len >> (LEN_BITS * w_win));
                        r_arsize  <= 2'(ch_size >> (2 * w_win));
                    end
                end
                default: begin
                    // Command is held until accepted; requester drops are ignored here.
                    if (ARREADY) begin
                        r_state   <= IDLE;
                        r_arvalid <= 1'b0;
                        r_rr_ptr  <= r_arid;
                    end
                end
            endcase
        end
    end

    // Outstanding bursts: simultaneous issue and completion cancel; underflow clamps at 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_outs <= '0;
        end else if (w_hs && !w_rdone) begin
            r_outs <= r_outs + 4'd1;
        end else if (!w_hs && w_rdone && (r_outs != 4'd0)) begin
            r_outs <= r_outs - 4'd1;
        end
    end

    assign ch_gnt   = w_hs ? (CH_NUM'(1) << r_arid) : '0;
    assign ARID     = r_arid;
    assign ARADDR   = r_araddr;
    assign ARLEN    = r_arlen;
    assign ARSIZE   = r_arsize;
    assign ARVALID  = r_arvalid;
    assign outs_cnt = r_outs;
    assign idle     = (r_state == IDLE) && (r_outs == 4'd0) && (ch_req == '0);

endmodule
